// File: rtl/pu_tag_hash_mem_nway.sv
// rtl/pu_tag_hash_mem_nway.sv - N-way tag hash bucket memory with per-way app read ports and a shared PIO port
module pu_tag_hash_mem_nway #(
    parameter int NUM_WAYS     = 4,
    parameter int WAY_NBITS    = 2,
    parameter int DEPTH_NBITS  = 10,
    parameter int BUCKET_NBITS = 96,
    parameter int PIO_NBITS    = 32,
    parameter int WORD_NBITS   = 2,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PIO_NBITS-1:0]             reg_addr,
    input  logic [PIO_NBITS-1:0]             reg_din,
    input  logic                             reg_rd,
    input  logic                             reg_wr,
    input  logic                             reg_ms,
    output logic                             mem_ack,
    output logic [PIO_NBITS-1:0]             mem_rdata,
    output logic [NUM_WAYS-1:0]              pio_hold,
    input  logic [NUM_WAYS-1:0]              app_rd,
    input  logic [NUM_WAYS*DEPTH_NBITS-1:0]  app_raddr,
    output logic [NUM_WAYS-1:0]              app_ack,
    output logic [NUM_WAYS*BUCKET_NBITS-1:0] app_rdata
);
    localparam int WORDS        = (BUCKET_NBITS + PIO_NBITS - 1) / PIO_NBITS;
    localparam int FULL_NBITS   = WORDS * PIO_NBITS;
    localparam int STAGE_NBITS  = FULL_NBITS - PIO_NBITS;
    localparam int ADDR_NBITS   = WAY_NBITS + DEPTH_NBITS + WORD_NBITS;
    localparam int STARVE_NBITS = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RD_PIPE, S_ACK} state_t;

    state_t                        state_q;
    logic [WAY_NBITS-1:0]          way_q;
    logic [DEPTH_NBITS-1:0]        entry_q;
    logic [WORD_NBITS-1:0]         word_q;
    logic [PIO_NBITS-1:0]          din_q;
    logic                          is_rd_q;
    logic [STAGE_NBITS-1:0]        staging_q;
    logic [STARVE_NBITS-1:0]       starve_q;
    logic [NUM_WAYS-1:0]           hold_q;
    logic                          pipe_cnt_q;
    logic [BUCKET_NBITS-1:0]       pio_data_q;
    logic                          mem_ack_q;
    logic [PIO_NBITS-1:0]          mem_rdata_q;
    logic [NUM_WAYS-1:0]           app_v1_q;
    logic [NUM_WAYS-1:0]           app_ack_q;
    logic [NUM_WAYS*BUCKET_NBITS-1:0] app_rdata_q;

    logic                          slot_free;
    logic                          pio_grant;
    logic                          pio_rd_issue;
    logic                          pio_commit;
    logic [FULL_NBITS-1:0]         commit_full;
    logic [BUCKET_NBITS-1:0]       commit_bucket;
    logic [FULL_NBITS-1:0]         pio_full;
    logic [PIO_NBITS-1:0]          pio_word;
    logic [NUM_WAYS*BUCKET_NBITS-1:0] bank_all;
    logic                          unused_addr_bits;

    assign unused_addr_bits = ^reg_addr[PIO_NBITS-1:ADDR_NBITS];

    // The application always owns its way's port; PIO only gets cycles the app leaves idle.
    assign slot_free     = ~app_rd[way_q];
    assign pio_grant     = (state_q == S_WAIT) && slot_free;
    assign pio_rd_issue  = pio_grant && is_rd_q;
    assign pio_commit    = pio_grant && !is_rd_q && !rst &&
                           (word_q == WORD_NBITS'(WORDS - 1));
    assign commit_full   = {din_q, staging_q};
    assign commit_bucket = commit_full[BUCKET_NBITS-1:0];
    assign pio_full      = FULL_NBITS'(pio_data_q);

    always_comb begin
        pio_word = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (word_q == WORD_NBITS'(w)) pio_word = pio_full[w*PIO_NBITS +: PIO_NBITS];
        end
    end

    for (genvar i = 0; i < NUM_WAYS; i++) begin : g_way
        logic [BUCKET_NBITS-1:0] mem_q [2**DEPTH_NBITS];
        logic [BUCKET_NBITS-1:0] rd_q;
        logic [DEPTH_NBITS-1:0]  rd_addr;
        logic                    pio_sel;

        assign pio_sel = (way_q == WAY_NBITS'(i));
        assign rd_addr = app_rd[i] ? app_raddr[i*DEPTH_NBITS +: DEPTH_NBITS] : entry_q;

        // Registered read sees pre-commit contents when read and commit share a cycle.
        always_ff @(posedge clk) begin
            if (app_rd[i] || (pio_rd_issue && pio_sel)) rd_q <= mem_q[rd_addr];
            if (pio_commit && pio_sel) mem_q[entry_q] <= commit_bucket;
        end

        assign bank_all[i*BUCKET_NBITS +: BUCKET_NBITS] = rd_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            app_v1_q    <= '0;
            app_ack_q   <= '0;
            app_rdata_q <= '0;
        end else begin
            app_v1_q  <= app_rd;
            app_ack_q <= app_v1_q;
            for (int i = 0; i < NUM_WAYS; i++) begin
                if (app_v1_q[i]) begin
                    app_rdata_q[i*BUCKET_NBITS +: BUCKET_NBITS] <=
                        bank_all[i*BUCKET_NBITS +: BUCKET_NBITS];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            way_q       <= '0;
            entry_q     <= '0;
            word_q      <= '0;
            din_q       <= '0;
            is_rd_q     <= 1'b0;
            staging_q   <= '0;
            starve_q    <= '0;
            hold_q      <= '0;
            pipe_cnt_q  <= 1'b0;
            pio_data_q  <= '0;
            mem_ack_q   <= 1'b0;
            mem_rdata_q <= '0;
        end else begin
            mem_ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (reg_ms && (reg_rd || reg_wr)) begin
                        word_q  <= reg_addr[WORD_NBITS-1:0];
                        entry_q <= reg_addr[WORD_NBITS +: DEPTH_NBITS];
                        way_q   <= reg_addr[WORD_NBITS+DEPTH_NBITS +: WAY_NBITS];
                        din_q   <= reg_din;
                        is_rd_q <= reg_rd;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!slot_free) begin
                        if (starve_q != STARVE_NBITS'(STARVE_LIMIT)) starve_q <= starve_q + 1'b1;
                        if (starve_q >= STARVE_NBITS'(STARVE_LIMIT - 1)) hold_q[way_q] <= 1'b1;
                    end else begin
                        starve_q      <= '0;
                        hold_q[way_q] <= 1'b0;
                        if (is_rd_q) begin
                            pipe_cnt_q <= 1'b0;
                            state_q    <= S_RD_PIPE;
                        end else begin
                            // Out-of-range and commit words leave staging untouched.
                            for (int w = 0; w < WORDS - 1; w++) begin
                                if (word_q == WORD_NBITS'(w)) staging_q[w*PIO_NBITS +: PIO_NBITS] <= din_q;
                            end
                            mem_ack_q <= 1'b1;
                            state_q   <= S_ACK;
                        end
                    end
                end
                S_RD_PIPE: begin
                    if (!pipe_cnt_q) begin
                        pio_data_q <= bank_all[way_q*BUCKET_NBITS +: BUCKET_NBITS];
                        pipe_cnt_q <= 1'b1;
                    end else begin
                        mem_rdata_q <= pio_word;
                        mem_ack_q   <= 1'b1;
                        state_q     <= S_ACK;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_ack   = mem_ack_q;
    assign mem_rdata = mem_rdata_q;
    assign pio_hold  = hold_q;
    assign app_ack   = app_ack_q;
    assign app_rdata = app_rdata_q;

endmodule

// File: tb/tb_pu_tag_hash_mem_nway.sv
// tb/tb_pu_tag_hash_mem_nway.sv - directed self-checking bench for pu_tag_hash_mem_nway
module tb_pu_tag_hash_mem_nway;
    localparam int NW = 4;
    localparam int DN = 10;
    localparam int BN = 96;
    localparam int PN = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [PN-1:0]     reg_addr;
    logic [PN-1:0]     reg_din;
    logic              reg_rd;
    logic              reg_wr;
    logic              reg_ms;
    logic              mem_ack;
    logic [PN-1:0]     mem_rdata;
    logic [NW-1:0]     pio_hold;
    logic [NW-1:0]     app_rd;
    logic [NW*DN-1:0]  app_raddr;
    logic [NW-1:0]     app_ack;
    logic [NW*BN-1:0]  app_rdata;

    int checks = 0;
    int errors = 0;
    logic iso_on = 1'b0;
    int iso_bad = 0;
    logic [BN-1:0] exp_iso [NW];

    pu_tag_hash_mem_nway dut (
        .clk(clk), .rst(rst),
        .reg_addr(reg_addr), .reg_din(reg_din), .reg_rd(reg_rd), .reg_wr(reg_wr), .reg_ms(reg_ms),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .pio_hold(pio_hold),
        .app_rd(app_rd), .app_raddr(app_raddr), .app_ack(app_ack), .app_rdata(app_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (iso_on) begin
            for (int w = 0; w < NW; w++) begin
                if (w != 2 && (app_ack[w] !== 1'b1 || app_rdata[w*BN +: BN] !== exp_iso[w])) iso_bad++;
            end
        end
    endtask

    function automatic logic [PN-1:0] pa(input int way, input int entry, input int word);
        return PN'((way << 12) | (entry << 2) | word);
    endfunction

    task automatic pio(input logic rd, input logic [PN-1:0] addr, input logic [PN-1:0] din,
                       output int lat, output logic [PN-1:0] rdata);
        reg_addr = addr; reg_din = din; reg_rd = rd; reg_wr = !rd; reg_ms = 1'b1;
        lat = 0; rdata = '0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            reg_rd = 1'b0; reg_wr = 1'b0;
            if (mem_ack === 1'b1) begin
                lat = n; rdata = mem_rdata;
                break;
            end
        end
        tick();
    endtask

    task automatic app_read(input int way, input int entry, output logic a1, output logic a2,
                            output logic [BN-1:0] data);
        app_rd[way] = 1'b1;
        app_raddr[way*DN +: DN] = DN'(entry);
        tick();
        app_rd[way] = 1'b0;
        a1 = app_ack[way];
        tick();
        a2 = app_ack[way];
        data = app_rdata[way*BN +: BN];
    endtask

    initial begin
        int lat;
        logic [PN-1:0] rd;
        logic a1, a2;
        logic [BN-1:0] bkt;
        logic seen_ack;
        int ack_bad;

        rst = 1'b1; reg_addr = '0; reg_din = '0; reg_rd = 1'b0; reg_wr = 1'b0; reg_ms = 1'b0;
        app_rd = '0; app_raddr = '0;
        tick(); tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("rst_mem_ack", mem_ack, 0);
        check("rst_mem_rdata", mem_rdata, 0);
        check("rst_pio_hold", pio_hold, 0);
        check("rst_app_ack", app_ack, 0);
        check("rst_app_rdata", 128'(app_rdata === '0), 1);

        // Wide write to way 2 entry 0x155 and readback
        pio(1'b0, pa(2, 'h155, 0), 32'h11111111, lat, rd);
        check("wr0_lat", lat, 2);
        pio(1'b0, pa(2, 'h155, 1), 32'h22222222, lat, rd);
        check("wr1_lat", lat, 2);
        pio(1'b0, pa(2, 'h155, 2), 32'h33333333, lat, rd);
        check("wr2_lat", lat, 2);
        app_read(2, 'h155, a1, a2, bkt);
        check("app2_ack_t1", a1, 0);
        check("app2_ack_t2", a2, 1);
        check("app2_bucket", bkt, 96'h333333332222222211111111);
        pio(1'b1, pa(2, 'h155, 1), '0, lat, rd);
        check("rd1_lat", lat, 4);
        check("rd1_data", rd, 32'h22222222);
        pio(1'b1, pa(2, 'h155, 2), '0, lat, rd);
        check("rd2_data", rd, 32'h33333333);

        // Module select low: strobe ignored
        reg_ms = 1'b0; reg_wr = 1'b1; reg_addr = pa(2, 'h155, 0); reg_din = 32'hDEADBEEF;
        seen_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            reg_wr = 1'b0;
            if (mem_ack === 1'b1) seen_ack = 1'b1;
        end
        check("ms_low_no_ack", seen_ack, 0);

        // Arbitration and starvation hold on way 1
        app_rd[1] = 1'b1;
        app_raddr[1*DN +: DN] = DN'('h155);
        tick(); tick();
        reg_ms = 1'b1; reg_rd = 1'b1; reg_addr = pa(1, 'h155, 0);
        tick();
        reg_rd = 1'b0;
        seen_ack = 1'b0; ack_bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_ack === 1'b1) seen_ack = 1'b1;
            if (app_ack[1] !== 1'b1) ack_bad++;
        end
        check("starve_no_ack", seen_ack, 0);
        check("starve_app_ack", ack_bad, 0);
        check("starve_hold", pio_hold, 4'b0010);
        app_rd[1] = 1'b0;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (mem_ack === 1'b1) begin lat = n; break; end
        end
        check("grant_lat", lat, 3);
        check("grant_hold_clr", pio_hold, 0);
        tick();

        // Way isolation: stream ways 0,1,3 while committing a bucket to way 2
        for (int w = 0; w < NW; w++) begin
            exp_iso[w] = {32'hA0000002 | 32'(w << 8), 32'hA0000001 | 32'(w << 8), 32'hA0000000 | 32'(w << 8)};
            if (w != 2) begin
                for (int k = 0; k < 3; k++) pio(1'b0, pa(w, 'h10, k), exp_iso[w][k*PN +: PN], lat, rd);
            end
        end
        app_rd = 4'b1011;
        for (int w = 0; w < NW; w++) app_raddr[w*DN +: DN] = DN'('h10);
        tick(); tick();
        iso_on = 1'b1;
        pio(1'b0, pa(2, 'h20, 0), 32'h0000CAFE, lat, rd);
        check("iso_wr0_lat", lat, 2);
        pio(1'b0, pa(2, 'h20, 1), 32'h0000BEEF, lat, rd);
        check("iso_wr1_lat", lat, 2);
        pio(1'b0, pa(2, 'h20, 2), 32'h00001234, lat, rd);
        check("iso_wr2_lat", lat, 2);
        iso_on = 1'b0;
        app_rd = '0;
        tick(); tick();
        check("iso_app_stream", iso_bad, 0);
        app_read(2, 'h20, a1, a2, bkt);
        check("iso_way2_bucket", bkt, 96'h000012340000BEEF0000CAFE);

        // Reset mid-operation clears staging
        pio(1'b0, pa(0, 5, 0), 32'hDEAD0000, lat, rd);
        pio(1'b0, pa(0, 5, 1), 32'hBEEF0001, lat, rd);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("midrst_mem_ack", mem_ack, 0);
        pio(1'b0, pa(0, 5, 2), 32'h000000AA, lat, rd);
        check("midrst_wr_lat", lat, 2);
        app_read(0, 5, a1, a2, bkt);
        check("midrst_ack", a2, 1);
        check("midrst_bucket", bkt, 96'h000000AA0000000000000000);

        // Out-of-range word index
        pio(1'b0, pa(2, 'h155, 3), 32'hFFFFFFFF, lat, rd);
        check("oor_wr_lat", lat, 2);
        app_read(2, 'h155, a1, a2, bkt);
        check("oor_bucket", bkt, 96'h333333332222222211111111);
        pio(1'b1, pa(2, 'h155, 3), '0, lat, rd);
        check("oor_rd_lat", lat, 4);
        check("oor_rd_data", rd, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
